// File: rtl/seq_detector.sv
// Serial pattern detector: shifts in one bit per clock and flags (registered,
// one cycle) every overlapping occurrence of SEQ in the most recent SEQ_LEN bits.
module seq_detector #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b0011
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    // fill doubles as the FSM state: S0..S(SEQ_LEN-1) while filling, FULL afterwards
    localparam logic [FILL_W-1:0] S0   = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] LAST = FILL_W'(SEQ_LEN - 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] hist_r;
    logic [SEQ_LEN-1:0] nxt_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_nxt_s;
    logic               match_s;

    function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] cnt);
        logic [FILL_W-1:0] res;
        if (cnt >= FULL) begin
            res = FULL;
        end else begin
            res = cnt + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Next history, next fill state and match decision for the incoming bit
    always_comb begin
        nxt_s      = {hist_r[SEQ_LEN-2:0], in};
        fill_nxt_s = sat_inc(fill_r);
        match_s    = 1'b0;
        // an unknown bit makes the compare unknown, which falls to the no-match branch
        if ((fill_r >= LAST) && (nxt_s == SEQ)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // State and registered match flag; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= {SEQ_LEN{1'b0}};
            fill_r <= S0;
            out    <= 1'b0;
        end else begin
            hist_r <= nxt_s;
            fill_r <= fill_nxt_s;
            out    <= match_s;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a default-pattern instance and a 1111 instance,
// driven from hand-computed bit/expectation tables.
module tb_seq_detector;

    logic clk;
    logic rst;
    logic in_a;
    logic in_b;
    logic out_a;
    logic out_b;

    typedef struct {
        int    dut;
        string name;
        logic  exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    seq_detector dut_a (
        .clk(clk),
        .rst(rst),
        .in (in_a),
        .out(out_a)
    );

    seq_detector #(
        .SEQ_LEN(4),
        .SEQ    (4'b1111)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .in (in_b),
        .out(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%b expected=%b", name, act, exp);
        end
    endtask

    // Monitor: one expected value is retired on every falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, (e.dut == 1) ? out_b : out_a, e.exp);
        end
    end

    task automatic send(input int dut, input string name, input logic b, input logic exp);
        exp_t e;
        #2;
        in_a = (dut == 0) ? b : 1'b0;
        in_b = (dut == 1) ? b : 1'b0;
        @(posedge clk);
        e.dut  = dut;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // bits/exps are written oldest-first: index n-1 is the first bit driven
    task automatic run_vec(input int dut, input string name, input logic [15:0] bits,
                           input logic [15:0] exps, input int n);
        for (int k = 0; k < n; k++) begin
            send(dut, $sformatf("%s[%0d]", name, k), bits[n-1-k], exps[n-1-k]);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk({name, "_async_a"}, out_a, 1'b0);
        chk({name, "_async_b"}, out_b, 1'b0);
        @(posedge clk);
        #1;
        chk({name, "_held_a"}, out_a, 1'b0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        in_a    = 1'b0;
        in_b    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state_a", out_a, 1'b0);
        chk("reset_state_b", out_b, 1'b0);
        rst = 1'b0;

        run_vec(0, "zeros", 16'b00000000, 16'b00000000, 8);

        do_reset("r1");
        run_vec(0, "single", 16'b00110, 16'b00010, 5);

        do_reset("r2");
        run_vec(0, "double", 16'b0011001111, 16'b0001000100, 10);

        // partial pattern interrupted by reset must not complete afterwards
        do_reset("r3");
        run_vec(0, "pre_rst", 16'b001, 16'b000, 3);
        do_reset("r4");
        run_vec(0, "post_rst", 16'b10, 16'b00, 2);

        // cleared history is zeros, so 1,1 would match without the fill gate
        do_reset("r5");
        run_vec(0, "fill_gate", 16'b110, 16'b000, 3);

        do_reset("r6");
        run_vec(0, "late", 16'b0110011, 16'b0000001, 7);

        do_reset("r7");
        run_vec(1, "ones", 16'b1111110, 16'b0001110, 7);

        // reset while out is high clears it without a clock edge
        do_reset("r8");
        run_vec(1, "ones_hi", 16'b1111, 16'b0001, 4);
        @(negedge clk);
        #1;
        chk("before_async_b", out_b, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_clear_b", out_b, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_vec(1, "ones_fresh", 16'b1111, 16'b0001, 4);

        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
